// File: rtl/fta_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fta_bus_pkg                                                      |
// | Purpose  : FTA 128-bit command bus types shared by initiators and targets, |
// |            plus the queue-entry type used by the memory responder.         |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package fta_bus_pkg;

  localparam int FTA_LINE_BYTES = 16;
  // Index field is sized for the largest supported RAM (65536 lines).
  localparam int FTA_MEM_IDX_W  = 16;

  typedef struct packed {
    logic [5:0] core;
    logic [2:0] channel;
    logic [6:0] tranid;
  } fta_tranid_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic [4:0]   cmd;
    logic [1:0]   bte;
    logic [2:0]   cti;
    logic [5:0]   blen;
    logic [2:0]   sz;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  vadr;
    logic [31:0]  padr;
    logic [127:0] data1;
    logic [127:0] data2;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic         stall;
    logic         next;
    logic         ack;
    logic         rty;
    logic         err;
    logic [3:0]   pri;
    logic [31:0]  adr;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  // One queued command for the memory responder.
  typedef struct packed {
    logic                     we;
    logic [15:0]              sel;
    logic [FTA_MEM_IDX_W-1:0] index;
    logic [31:0]              padr;
    logic [127:0]             data1;
    fta_tranid_t              tid;
  } fta_mem_cmd_t;

endpackage
`default_nettype wire

// File: rtl/fta_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fta_req_fifo                                                     |
// | Purpose  : Synchronous show-ahead FIFO; rdata is valid whenever empty==0.  |
// |            A push while full is refused even if a pop happens that cycle. |
// | Ports    : clk, rst (sync, active-low), push/wdata, pop/rdata,             |
// |            full, empty, count (occupancy).                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fta_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] store [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage carries no reset; stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/fta_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fta_mem_responder                                                |
// | Purpose  : FTA-bus target backed by a 128-bit byte-enabled block RAM.      |
// |            Commands hitting the window are queued, executed in order and  |
// |            answered with one response each (tid echoed).                   |
// | Ports    : clk  - clock                                                    |
// |            rst  - synchronous active-low reset (RAM contents retained)     |
// |            req  - fta_cmd_request128_t command from the bus                |
// |            resp - fta_cmd_response128_t (ack, rty, tid, adr, dat)          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module fta_mem_responder
  import fta_bus_pkg::*;
#(
  parameter logic [31:0] BASE      = 32'hFFFC0000,
  parameter int          DEPTH     = 1024,
  parameter int          QDEPTH    = 4,
  parameter bit          WR_ACK    = 1'b1,
  parameter              INIT_FILE = ""
) (
  input  logic                 clk,
  input  logic                 rst,
  input  fta_cmd_request128_t  req,
  output fta_cmd_response128_t resp
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [31:0] WIN_MASK = 32'(DEPTH * FTA_LINE_BYTES - 1);

  logic                     hit;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic [$clog2(QDEPTH):0]  q_count;
  fta_mem_cmd_t             entry;
  fta_mem_cmd_t             head;
  logic [IDX_W-1:0]         head_idx;

  logic [127:0]             ram [DEPTH];

  // S1 -> S2 pipeline register
  logic                     s1_valid;
  logic                     s1_we;
  logic [31:0]              s1_padr;
  fta_tranid_t              s1_tid;
  logic [127:0]             s1_rdata;

  // ---------------------------------------------------------------- decode / S0
  assign hit  = req.cyc & ((req.padr & ~WIN_MASK) == BASE);
  assign push = hit & ~full;

  always_comb begin
    entry       = '0;
    entry.we    = req.we;
    entry.sel   = req.sel;
    entry.index = FTA_MEM_IDX_W'(req.padr[4 +: IDX_W]);
    entry.padr  = req.padr;
    entry.data1 = req.data1;
    entry.tid   = req.tid;
  end

  fta_req_fifo #(
    .WIDTH ($bits(fta_mem_cmd_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (entry),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (q_count)
  );

  // ---------------------------------------------------------------- S1: RAM
  // Popping is held off during reset so a discarded command never touches RAM.
  assign pop      = ~empty & rst;
  assign head_idx = head.index[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (pop && head.we) begin
      for (int i = 0; i < FTA_LINE_BYTES; i++) begin
        if (head.sel[i]) ram[head_idx][8*i +: 8] <= head.data1[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_we    <= 1'b0;
      s1_padr  <= '0;
      s1_tid   <= '0;
      s1_rdata <= '0;
    end else begin
      s1_valid <= pop;
      if (pop) begin
        s1_we    <= head.we;
        s1_padr  <= head.padr;
        s1_tid   <= head.tid;
        s1_rdata <= ram[head_idx];
      end
    end
  end

  // ---------------------------------------------------------------- S2: response
  always_ff @(posedge clk) begin
    if (!rst) begin
      resp <= '0;
    end else begin
      resp     <= '0;
      resp.rty <= full;
      if (s1_valid && (!s1_we || WR_ACK)) begin
        resp.ack <= 1'b1;
        resp.tid <= s1_tid;
        resp.adr <= s1_padr;
        resp.dat <= s1_we ? 128'd0 : s1_rdata;
      end
    end
  end

  // Request fields this target does not interpret.
  logic unused_bits;
  assign unused_bits = ^{req.cmd, req.bte, req.cti, req.blen, req.sz, req.stb,
                         req.vadr, req.data2, head.index, q_count};

endmodule
`default_nettype wire

// File: tb/tb_fta_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fta_mem_responder                                             |
// | Purpose  : Directed self-checking bench for fta_mem_responder.             |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_fta_mem_responder;
  import fta_bus_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFC0000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  fta_cmd_request128_t  req = '0;
  fta_cmd_response128_t resp;

  int errors = 0;
  int checks = 0;

  fta_mem_responder #(
    .BASE   (BASE),
    .DEPTH  (1024),
    .QDEPTH (4),
    .WR_ACK (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .resp (resp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [15:0] sel, input logic [31:0] padr,
                       input logic [127:0] data, input logic [2:0] ch, input logic [6:0] tr);
    req             = '0;
    req.cyc         = 1'b1;
    req.stb         = 1'b1;
    req.we          = we;
    req.sel         = sel;
    req.padr        = padr;
    req.data1       = data;
    req.tid.channel = ch;
    req.tid.tranid  = tr;
  endtask

  task automatic idle();
    req = '0;
  endtask

  // Issue one command into an empty queue; return resp after edges N+1 and N+2.
  task automatic run_cmd(input logic we, input logic [15:0] sel, input logic [31:0] padr,
                         input logic [127:0] data, input logic [2:0] ch, input logic [6:0] tr,
                         output fta_cmd_response128_t r_mid, output fta_cmd_response128_t r);
    drive(we, sel, padr, data, ch, tr);
    step();
    idle();
    step();
    r_mid = resp;
    step();
    r = resp;
  endtask

  task automatic test_reset();
    int acks;
    rst = 1'b0;
    idle();
    repeat (3) step();
    checks++;
    if (resp !== '0) begin
      errors++; $display("FAIL reset_resp: got %h expected 0", resp);
    end
    checks++;
    if (resp.rty !== 1'b0) begin
      errors++; $display("FAIL reset_rty: got %b expected 0", resp.rty);
    end
    rst  = 1'b1;
    acks = 0;
    repeat (4) begin
      step();
      if (resp.ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL idle_acks: got %0d expected 0", acks);
    end
  endtask

  task automatic test_write_read();
    fta_cmd_response128_t rm, r;
    logic [127:0] d;
    d = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    run_cmd(1'b1, 16'hFFFF, BASE + 32'h40, d, 3'd1, 7'd1, rm, r);
    checks++;
    if (rm.ack !== 1'b0) begin
      errors++; $display("FAIL wr_early_ack: got %b expected 0", rm.ack);
    end
    checks++;
    if (r.ack !== 1'b1 || r.tid.channel !== 3'd1 || r.tid.tranid !== 7'd1) begin
      errors++; $display("FAIL wr_ack: got ack=%b ch=%0d tr=%0d expected ack=1 ch=1 tr=1",
                         r.ack, r.tid.channel, r.tid.tranid);
    end
    checks++;
    if (r.dat !== 128'd0 || r.adr !== BASE + 32'h40 || r.err !== 1'b0) begin
      errors++; $display("FAIL wr_fields: got dat=%h adr=%h err=%b expected dat=0 adr=%h err=0",
                         r.dat, r.adr, r.err, BASE + 32'h40);
    end
    run_cmd(1'b0, 16'hFFFF, BASE + 32'h40, 128'd0, 3'd0, 7'd2, rm, r);
    checks++;
    if (r.ack !== 1'b1 || r.dat !== d) begin
      errors++; $display("FAIL rd_data: got ack=%b dat=%h expected ack=1 dat=%h", r.ack, r.dat, d);
    end
    checks++;
    if (r.tid.channel !== 3'd0 || r.tid.tranid !== 7'd2 || r.adr !== BASE + 32'h40) begin
      errors++; $display("FAIL rd_tid: got ch=%0d tr=%0d adr=%h expected ch=0 tr=2 adr=%h",
                         r.tid.channel, r.tid.tranid, r.adr, BASE + 32'h40);
    end
    step();
    checks++;
    if (resp.ack !== 1'b0 || resp.dat !== 128'd0) begin
      errors++; $display("FAIL ack_pulse: got ack=%b dat=%h expected ack=0 dat=0", resp.ack, resp.dat);
    end
  endtask

  task automatic test_byte_enables();
    fta_cmd_response128_t rm, r;
    logic [127:0] exp_d;
    exp_d = 128'hAAAA_AAAA_AAAA_AAAA_AAAA_AAAA_AAAA_5511;
    run_cmd(1'b1, 16'hFFFF, BASE + 32'h100, {16{8'hAA}}, 3'd2, 7'd3, rm, r);
    run_cmd(1'b1, 16'h0003, BASE + 32'h100, 128'hFFFF_FFFF_0000_0000_1234_5678_9ABC_5511,
            3'd2, 7'd4, rm, r);
    run_cmd(1'b0, 16'hFFFF, BASE + 32'h100, 128'd0, 3'd2, 7'd5, rm, r);
    checks++;
    if (r.ack !== 1'b1 || r.dat !== exp_d) begin
      errors++; $display("FAIL byte_enable: got ack=%b dat=%h expected ack=1 dat=%h", r.ack, r.dat, exp_d);
    end
  endtask

  task automatic test_queue_full();
    int          acks;
    logic [6:0]  tids [8];
    logic        early_ack;
    early_ack = 1'b0;
    force dut.pop = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 16'hFFFF, BASE + 32'(16 * k), 128'd0, 3'd3, 7'(k));
      step();
      if (resp.ack === 1'b1) early_ack = 1'b1;
      if (k == 4) begin
        checks++;
        if (resp.rty !== 1'b0) begin
          errors++; $display("FAIL rty_at_4th: got %b expected 0", resp.rty);
        end
      end
      if (k == 5) begin
        checks++;
        if (resp.rty !== 1'b1) begin
          errors++; $display("FAIL rty_after_4th: got %b expected 1", resp.rty);
        end
      end
    end
    idle();
    step();
    checks++;
    if (resp.rty !== 1'b1 || early_ack) begin
      errors++; $display("FAIL stall_state: got rty=%b early_ack=%b expected rty=1 early_ack=0",
                         resp.rty, early_ack);
    end
    release dut.pop;
    acks = 0;
    repeat (12) begin
      step();
      if (resp.ack === 1'b1) begin
        if (acks < 8) tids[acks] = resp.tid.tranid;
        acks++;
      end
    end
    checks++;
    if (acks != 4) begin
      errors++; $display("FAIL full_ack_count: got %0d expected 4", acks);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= acks || tids[k] !== 7'(k + 1)) begin
        errors++; $display("FAIL full_order[%0d]: got %0d expected %0d", k,
                           (k < acks) ? int'(tids[k]) : -1, k + 1);
      end
    end
    checks++;
    if (resp.rty !== 1'b0) begin
      errors++; $display("FAIL rty_drain: got %b expected 0", resp.rty);
    end
  endtask

  task automatic test_out_of_window();
    fta_cmd_response128_t rm, r;
    int acks;
    logic [127:0] k;
    k = 128'hCAFE_F00D_0000_1111_2222_3333_4444_5555;
    run_cmd(1'b1, 16'hFFFF, BASE + 32'h3FF0, k, 3'd4, 7'd10, rm, r);
    drive(1'b1, 16'hFFFF, BASE - 32'd16, 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF, 3'd4, 7'd11);
    step();
    idle();
    acks = 0;
    repeat (4) begin
      step();
      if (resp.ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0 || resp.rty !== 1'b0) begin
      errors++; $display("FAIL oow_ignored: got acks=%0d rty=%b expected acks=0 rty=0", acks, resp.rty);
    end
    run_cmd(1'b0, 16'hFFFF, BASE + 32'h3FF0, 128'd0, 3'd4, 7'd12, rm, r);
    checks++;
    if (r.ack !== 1'b1 || r.dat !== k) begin
      errors++; $display("FAIL oow_ram: got ack=%b dat=%h expected ack=1 dat=%h", r.ack, r.dat, k);
    end
  endtask

  task automatic test_reset_mid();
    fta_cmd_response128_t rm, r;
    int acks;
    logic [127:0] m;
    m = 128'h1357_9BDF_2468_ACE0_0F1E_2D3C_4B5A_6978;
    run_cmd(1'b1, 16'hFFFF, BASE + 32'h200, m, 3'd5, 7'd20, rm, r);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 16'hFFFF, BASE + 32'h200, 128'd0, 3'd5, 7'(21 + k));
      step();
    end
    idle();
    rst = 1'b0;
    step();
    checks++;
    if (resp !== '0) begin
      errors++; $display("FAIL midreset_resp: got %h expected 0", resp);
    end
    step();
    rst  = 1'b1;
    acks = 0;
    repeat (6) begin
      step();
      if (resp.ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++; $display("FAIL midreset_acks: got %0d expected 0", acks);
    end
    run_cmd(1'b0, 16'hFFFF, BASE + 32'h200, 128'd0, 3'd5, 7'd30, rm, r);
    checks++;
    if (r.ack !== 1'b1 || r.dat !== m || r.tid.tranid !== 7'd30) begin
      errors++; $display("FAIL midreset_ram: got ack=%b dat=%h tr=%0d expected ack=1 dat=%h tr=30",
                         r.ack, r.dat, r.tid.tranid, m);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enables();
    test_queue_full();
    test_out_of_window();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
